// File: rtl/membus_arbiter.sv
// ---------------------------------------------------------------------------
// membus_arbiter
//
// Shares a single memory/MMIO bus between the instruction-fetch port (i_*)
// and the load/store port (d_*).  Only one transaction may be outstanding at
// a time.  The response is routed back to the port that issued the request.
//
// The data port normally has priority.  A starvation counter tracks how many
// data grants in a row were made while fetch was also waiting.  Once that
// count reaches STARVE_LIMIT, fetch wins the next contested arbitration.
//
// Parameters:
//   ADDR_WIDTH   - address width
//   DATA_WIDTH   - data width (must be a multiple of 8)
//   STARVE_LIMIT - data grants in a row, with fetch pending, before fetch
//                  is forced to win once (>= 1)
//
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   i_valid/i_ready     - fetch request handshake, i_addr is the fetch address
//   i_rvalid/i_rdata    - fetch response
//   d_valid/d_ready     - data request handshake
//   d_addr/d_wen        - data address and store (1) / load (0) select
//   d_wdata/d_wmask     - store data and byte mask
//   d_rvalid/d_rdata    - data response (both loads and stores get one)
//   m_valid/m_ready     - downstream request handshake
//   m_addr/m_wen        - downstream address and write enable
//   m_wdata/m_wmask     - downstream store data and byte mask
//   m_rvalid/m_rdata    - downstream response, one per accepted request
// ---------------------------------------------------------------------------
module membus_arbiter #(
    parameter int ADDR_WIDTH   = 64,
    parameter int DATA_WIDTH   = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_rvalid,
    output logic [DATA_WIDTH-1:0]   i_rdata,

    input  logic                    d_valid,
    output logic                    d_ready,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic                    d_wen,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wmask,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,

    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic                    m_wen,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wmask,
    input  logic                    m_rvalid,
    input  logic [DATA_WIDTH-1:0]   m_rdata
);

    localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STARVE_LIMIT);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_t;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   starve_cnt;
    logic                   fetch_win;
    logic                   data_win;
    logic                   handshake;

    // Arbitration is only meaningful in IDLE.  Fetch wins when it is the only
    // requester, or when data has already been granted STARVE_LIMIT times in
    // a row while fetch waited.  In every other case a pending data request
    // wins.  In the wait states neither port wins, which also blocks both
    // readies and m_valid without any extra gating further down.
    always_comb begin
        fetch_win = 1'b0;
        data_win  = 1'b0;
        if (state == IDLE) begin
            fetch_win = i_valid && (!d_valid || (starve_cnt == CNT_MAX));
            data_win  = d_valid && !fetch_win;
        end
    end

    // m_valid depends only on the requesters and the state, never on m_ready.
    // The handshake therefore cannot form a combinational loop with a
    // downstream that derives m_ready from m_valid.
    assign m_valid   = fetch_win || data_win;
    assign handshake = m_valid && m_ready;
    assign i_ready   = fetch_win && m_ready;
    assign d_ready   = data_win && m_ready;

    // Request mux.  A fetch is always a read, so the write fields are forced
    // to zero.  When no one is requesting, all fields are zero so the bus
    // does not show stale requester data.
    always_comb begin
        m_addr  = '0;
        m_wen   = 1'b0;
        m_wdata = '0;
        m_wmask = '0;
        if (fetch_win) begin
            m_addr = i_addr;
        end else if (data_win) begin
            m_addr  = d_addr;
            m_wen   = d_wen;
            m_wdata = d_wdata;
            m_wmask = d_wmask;
        end
    end

    // Response routing.  The owner is known from the wait state, so the
    // response is passed straight through in the same cycle.  A response in
    // IDLE has no owner.  It can only come from a downstream that was not
    // reset with us, and it is dropped.  The non-owner data bus is held at
    // zero.
    always_comb begin
        i_rvalid = (state == WAIT_I) && m_rvalid;
        d_rvalid = (state == WAIT_D) && m_rvalid;
        i_rdata  = i_rvalid ? m_rdata : '0;
        d_rdata  = d_rvalid ? m_rdata : '0;
    end

    // Transaction FSM and starvation counter.  The counter only moves on an
    // accepted request.  It grows, saturating, while data keeps winning with
    // fetch waiting.  It clears whenever fetch is served, and also when data
    // wins with no fetch waiting, because then nobody was starved.  The
    // response cycle always returns to IDLE.  Any new request is therefore
    // arbitrated one cycle later, using the fresh counter value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        if (fetch_win) begin
                            state      <= WAIT_I;
                            starve_cnt <= '0;
                        end else begin
                            state <= WAIT_D;
                            if (!i_valid) begin
                                starve_cnt <= '0;
                            end else if (starve_cnt != CNT_MAX) begin
                                starve_cnt <= starve_cnt + CNT_ONE;
                            end
                        end
                    end
                end
                WAIT_I, WAIT_D: begin
                    if (m_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_membus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_membus_arbiter
//
// Self-checking bench for membus_arbiter.  A set of directed scenarios is
// followed by a randomized run.  The randomized run is checked against a
// transaction-level model: who owns the bus, and how many data grants in a
// row fetch has sat through.
// ---------------------------------------------------------------------------
module tb_membus_arbiter;

    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int MW    = DW / 8;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          i_ready;
    logic [AW-1:0] i_addr;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_valid;
    logic          d_ready;
    logic [AW-1:0] d_addr;
    logic          d_wen;
    logic [DW-1:0] d_wdata;
    logic [MW-1:0] d_wmask;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          m_valid;
    logic          m_ready;
    logic [AW-1:0] m_addr;
    logic          m_wen;
    logic [DW-1:0] m_wdata;
    logic [MW-1:0] m_wmask;
    logic          m_rvalid;
    logic [DW-1:0] m_rdata;

    int compared   = 0;
    int mismatched = 0;

    membus_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_addr  (i_addr),
        .i_rvalid(i_rvalid),
        .i_rdata (i_rdata),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .d_addr  (d_addr),
        .d_wen   (d_wen),
        .d_wdata (d_wdata),
        .d_wmask (d_wmask),
        .d_rvalid(d_rvalid),
        .d_rdata (d_rdata),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_addr  (m_addr),
        .m_wen   (m_wen),
        .m_wdata (m_wdata),
        .m_wmask (m_wmask),
        .m_rvalid(m_rvalid),
        .m_rdata (m_rdata)
    );

    // 10 ns clock.  Inputs change 1 ns after the rising edge.  Outputs are
    // sampled on the falling edge.
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Return a downstream response for one cycle.
    task automatic respond(input logic [DW-1:0] data);
        m_rvalid = 1'b1;
        m_rdata  = data;
        tick();
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    task automatic clear_inputs();
        i_valid  = 1'b0;
        i_addr   = '0;
        d_valid  = 1'b0;
        d_addr   = '0;
        d_wen    = 1'b0;
        d_wdata  = '0;
        d_wmask  = '0;
        m_ready  = 1'b1;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    // Reset with no traffic: no responses, and no request on the bus.
    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (i_rvalid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_i_rvalid: got %0b want 0", i_rvalid);
        end
        compared++;
        if (d_rvalid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_d_rvalid: got %0b want 0", d_rvalid);
        end
        compared++;
        if (m_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_m_valid: got %0b want 0", m_valid);
        end
        tick();
    endtask

    // A lone fetch goes straight out.  Its response comes back two cycles
    // later, on the fetch port only.
    task automatic test_fetch_only();
        i_valid = 1'b1;
        i_addr  = 64'h1000;
        m_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (m_valid !== 1'b1 || m_addr !== 64'h1000 || m_wen !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL fetch_request: got valid=%0b addr=%h wen=%0b want 1/1000/0", m_valid, m_addr, m_wen);
        end
        compared++;
        if (i_ready !== 1'b1 || d_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL fetch_ready: got i=%0b d=%0b want 1/0", i_ready, d_ready);
        end
        tick();
        i_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (m_valid !== 1'b0 || i_rvalid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL fetch_waiting: got m_valid=%0b i_rvalid=%0b want 0/0", m_valid, i_rvalid);
        end
        tick();
        m_rvalid = 1'b1;
        m_rdata  = 64'h13;
        @(negedge clk);
        compared++;
        if (i_rvalid !== 1'b1 || i_rdata !== 64'h13 || d_rvalid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL fetch_response: got i_rvalid=%0b i_rdata=%h d_rvalid=%0b want 1/13/0", i_rvalid, i_rdata, d_rvalid);
        end
        tick();
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    // Both ports request together and data wins.  The fetch that was held
    // waiting is granted in the cycle after the write response.
    task automatic test_simultaneous();
        i_valid = 1'b1;
        i_addr  = 64'h1100;
        d_valid = 1'b1;
        d_addr  = 64'h2000;
        d_wen   = 1'b1;
        d_wdata = 64'hDEADBEEF;
        d_wmask = 8'h0F;
        @(negedge clk);
        compared++;
        if (m_addr !== 64'h2000 || m_wen !== 1'b1 || m_wmask !== 8'h0F || m_wdata !== 64'hDEADBEEF) begin
            mismatched++;
            $display("[TB] FAIL simul_request: got addr=%h wen=%0b mask=%h wdata=%h want 2000/1/0f/deadbeef", m_addr, m_wen, m_wmask, m_wdata);
        end
        compared++;
        if (d_ready !== 1'b1 || i_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL simul_ready: got d=%0b i=%0b want 1/0", d_ready, i_ready);
        end
        tick();
        d_valid = 1'b0;
        d_wen   = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 64'h0;
        @(negedge clk);
        compared++;
        if (d_rvalid !== 1'b1 || i_rvalid !== 1'b0 || m_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL simul_wr_response: got d_rvalid=%0b i_rvalid=%0b m_valid=%0b want 1/0/0", d_rvalid, i_rvalid, m_valid);
        end
        tick();
        m_rvalid = 1'b0;
        @(negedge clk);
        compared++;
        if (m_valid !== 1'b1 || m_addr !== 64'h1100 || i_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL simul_fetch_next: got valid=%0b addr=%h i_ready=%0b want 1/1100/1", m_valid, m_addr, i_ready);
        end
        tick();
        i_valid = 1'b0;
        respond(64'h55);
    endtask

    // Fetch is held high while data requests keep arriving.  Expected grant
    // order is D D D D F D.  The last data grant proves that the counter
    // restarted after the forced fetch.
    task automatic test_starvation();
        int   dcnt;
        logic exp_fetch;
        dcnt    = 0;
        i_valid = 1'b1;
        i_addr  = 64'h3000;
        m_ready = 1'b1;
        for (int g = 0; g < 6; g++) begin
            d_valid   = 1'b1;
            d_wen     = 1'b0;
            d_addr    = 64'h4000 + 64'(dcnt * 8);
            exp_fetch = (g == LIMIT);
            @(negedge clk);
            compared++;
            if (i_ready !== exp_fetch || d_ready !== !exp_fetch) begin
                mismatched++;
                $display("[TB] FAIL starve_grant_%0d: got i_ready=%0b d_ready=%0b want %0b/%0b", g, i_ready, d_ready, exp_fetch, !exp_fetch);
            end
            compared++;
            if (m_addr !== (exp_fetch ? i_addr : d_addr)) begin
                mismatched++;
                $display("[TB] FAIL starve_addr_%0d: got %h want %h", g, m_addr, exp_fetch ? i_addr : d_addr);
            end
            tick();
            if (exp_fetch) begin
                i_addr = 64'h3100;
            end else begin
                dcnt++;
                d_addr = 64'h4000 + 64'(dcnt * 8);
            end
            m_rvalid = 1'b1;
            m_rdata  = 64'(g);
            @(negedge clk);
            compared++;
            if (i_rvalid !== exp_fetch || d_rvalid !== !exp_fetch) begin
                mismatched++;
                $display("[TB] FAIL starve_resp_%0d: got i_rvalid=%0b d_rvalid=%0b want %0b/%0b", g, i_rvalid, d_rvalid, exp_fetch, !exp_fetch);
            end
            tick();
            m_rvalid = 1'b0;
        end
        clear_inputs();
        tick();
    endtask

    // With m_ready held low, the request is held on the bus without change.
    task automatic test_backpressure();
        d_valid = 1'b1;
        d_addr  = 64'h5000;
        d_wen   = 1'b0;
        m_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            compared++;
            if (m_valid !== 1'b1 || d_ready !== 1'b0 || m_addr !== 64'h5000) begin
                mismatched++;
                $display("[TB] FAIL backpressure_%0d: got valid=%0b d_ready=%0b addr=%h want 1/0/5000", c, m_valid, d_ready, m_addr);
            end
            tick();
        end
        m_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (d_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL backpressure_accept: got d_ready=%0b want 1", d_ready);
        end
        tick();
        d_valid = 1'b0;
        @(negedge clk);
        compared++;
        if (m_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL backpressure_wait: got m_valid=%0b want 0", m_valid);
        end
        tick();
        respond(64'h77);
    endtask

    // A data request that arrives while a fetch is outstanding must wait.
    // It goes out in the cycle after the fetch response.
    task automatic test_blocking();
        i_valid = 1'b1;
        i_addr  = 64'h6000;
        tick();
        i_valid = 1'b0;
        d_valid = 1'b1;
        d_addr  = 64'h7000;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            compared++;
            if (m_valid !== 1'b0 || d_ready !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL blocking_%0d: got m_valid=%0b d_ready=%0b want 0/0", c, m_valid, d_ready);
            end
            tick();
        end
        m_rvalid = 1'b1;
        m_rdata  = 64'hABCD;
        @(negedge clk);
        compared++;
        if (i_rvalid !== 1'b1 || i_rdata !== 64'hABCD || m_valid !== 1'b0 || d_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL blocking_resp: got i_rvalid=%0b i_rdata=%h m_valid=%0b d_ready=%0b want 1/abcd/0/0", i_rvalid, i_rdata, m_valid, d_ready);
        end
        tick();
        m_rvalid = 1'b0;
        @(negedge clk);
        compared++;
        if (m_valid !== 1'b1 || m_addr !== 64'h7000 || d_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL blocking_release: got valid=%0b addr=%h d_ready=%0b want 1/7000/1", m_valid, m_addr, d_ready);
        end
        tick();
        d_valid = 1'b0;
        respond(64'h88);
    endtask

    // Reset while a data response is pending.  A late response must be
    // dropped, and the arbiter must be back in IDLE accepting requests.
    task automatic test_reset_mid();
        d_valid = 1'b1;
        d_addr  = 64'h8000;
        tick();
        d_valid = 1'b0;
        rst     = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (d_rvalid !== 1'b0 || m_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_idle: got d_rvalid=%0b m_valid=%0b want 0/0", d_rvalid, m_valid);
        end
        m_rvalid = 1'b1;
        m_rdata  = 64'h99;
        #1;
        compared++;
        if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_late_resp: got i_rvalid=%0b d_rvalid=%0b want 0/0", i_rvalid, d_rvalid);
        end
        tick();
        d_valid = 1'b1;
        d_addr  = 64'h8800;
        @(negedge clk);
        compared++;
        if (m_valid !== 1'b1 || d_ready !== 1'b1 || d_rvalid !== 1'b0 || i_rvalid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL rstmid_spurious_idle: got m_valid=%0b d_ready=%0b d_rvalid=%0b i_rvalid=%0b want 1/1/0/0", m_valid, d_ready, d_rvalid, i_rvalid);
        end
        tick();
        m_rvalid = 1'b0;
        d_valid  = 1'b0;
        respond(64'h0);
    endtask

    // Random traffic checked against the transaction model.  Owner values:
    // 0 means the bus is free, 1 means fetch owns it, 2 means data owns it.
    // streak counts data grants in a row made while fetch was waiting.
    task automatic test_random();
        int   owner;
        int   streak;
        logic exp_mv, exp_ir, exp_dr, exp_irv, exp_drv, f_wins, d_wins;
        logic [AW-1:0] exp_addr;
        logic          exp_wen;
        logic [DW-1:0] exp_wdata;
        logic [MW-1:0] exp_wmask;

        clear_inputs();
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        owner  = 0;
        streak = 0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!i_valid && ($urandom_range(0, 1) == 1)) begin
                i_valid = 1'b1;
                i_addr  = {$urandom, $urandom};
            end
            if (!d_valid && ($urandom_range(0, 3) != 0)) begin
                d_valid = 1'b1;
                d_addr  = {$urandom, $urandom};
                d_wen   = 1'($urandom_range(0, 1));
                d_wdata = {$urandom, $urandom};
                d_wmask = 8'($urandom);
            end
            m_ready  = ($urandom_range(0, 3) != 0);
            m_rvalid = ($urandom_range(0, 2) == 0);
            m_rdata  = {$urandom, $urandom};

            f_wins    = (owner == 0) && i_valid && (!d_valid || streak >= LIMIT);
            d_wins    = (owner == 0) && d_valid && !f_wins;
            exp_mv    = f_wins || d_wins;
            exp_ir    = f_wins && m_ready;
            exp_dr    = d_wins && m_ready;
            exp_irv   = (owner == 1) && m_rvalid;
            exp_drv   = (owner == 2) && m_rvalid;
            exp_addr  = f_wins ? i_addr : d_addr;
            exp_wen   = f_wins ? 1'b0 : d_wen;
            exp_wdata = f_wins ? '0 : d_wdata;
            exp_wmask = f_wins ? '0 : d_wmask;

            @(negedge clk);
            compared++;
            if (m_valid !== exp_mv || i_ready !== exp_ir || d_ready !== exp_dr) begin
                mismatched++;
                $display("[TB] FAIL rand_handshake cyc %0d: got v/ir/dr=%0b%0b%0b want %0b%0b%0b", cyc, m_valid, i_ready, d_ready, exp_mv, exp_ir, exp_dr);
            end
            compared++;
            if (i_rvalid !== exp_irv || d_rvalid !== exp_drv) begin
                mismatched++;
                $display("[TB] FAIL rand_rvalid cyc %0d: got i/d=%0b%0b want %0b%0b", cyc, i_rvalid, d_rvalid, exp_irv, exp_drv);
            end
            if (exp_mv) begin
                compared++;
                if (m_addr !== exp_addr || m_wen !== exp_wen || m_wdata !== exp_wdata || m_wmask !== exp_wmask) begin
                    mismatched++;
                    $display("[TB] FAIL rand_fields cyc %0d: got %h/%0b/%h/%h want %h/%0b/%h/%h", cyc, m_addr, m_wen, m_wdata, m_wmask, exp_addr, exp_wen, exp_wdata, exp_wmask);
                end
            end
            if (exp_irv || exp_drv) begin
                compared++;
                if ((exp_irv ? i_rdata : d_rdata) !== m_rdata) begin
                    mismatched++;
                    $display("[TB] FAIL rand_rdata cyc %0d: got %h want %h", cyc, exp_irv ? i_rdata : d_rdata, m_rdata);
                end
            end

            // Advance the model, and retire any request the model accepted.
            if (owner == 0 && exp_mv && m_ready) begin
                if (f_wins) begin
                    owner  = 1;
                    streak = 0;
                end else begin
                    owner  = 2;
                    streak = i_valid ? ((streak + 1 > LIMIT) ? LIMIT : streak + 1) : 0;
                end
            end else if (owner != 0 && m_rvalid) begin
                owner = 0;
            end
            tick();
            if (exp_ir) i_valid = 1'b0;
            if (exp_dr) d_valid = 1'b0;
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        $display("[TB] membus_arbiter bench starting");
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_starvation();
        test_backpressure();
        test_blocking();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/membus_arbiter.md
Name: membus_arbiter

Overview:
- Shares one memory bus between the instruction-fetch port (i_*) and the load/store port (d_*).
- Sits between the fetch stage / memory stage and the memory or MMIO bus.
- Allows one outstanding transaction at a time and routes the response back to the requester that owns it.
- Data port has priority; a starvation counter guarantees fetch forward progress.

Parameters:
ADDR_WIDTH, 64, address width (XLEN)
DATA_WIDTH, 64, data width (XLEN)
STARVE_LIMIT, 4, consecutive data-port grants with fetch pending before fetch is forced to win once (>=1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_valid  in  1  fetch request
i_ready  out  1  fetch request accepted
i_addr  in  ADDR_WIDTH  fetch address
i_rvalid  out  1  fetch response valid
i_rdata  out  DATA_WIDTH  fetch response data
d_valid  in  1  data request
d_ready  out  1  data request accepted
d_addr  in  ADDR_WIDTH  data address
d_wen  in  1  1 = store, 0 = load
d_wdata  in  DATA_WIDTH  store data
d_wmask  in  DATA_WIDTH/8  byte write mask
d_rvalid  out  1  data response valid (loads and stores)
d_rdata  out  DATA_WIDTH  load data
m_valid  out  1  downstream request
m_ready  in  1  downstream accepts request
m_addr  out  ADDR_WIDTH  downstream address
m_wen  out  1  downstream write enable
m_wdata  out  DATA_WIDTH  downstream store data
m_wmask  out  DATA_WIDTH/8  downstream byte mask
m_rvalid  in  1  downstream response (one per accepted request, reads and writes)
m_rdata  in  DATA_WIDTH  downstream response data

Behaviour:
Interface and reset:
- Single clock, clk. Reset is synchronous and active-high on rst.
- Reset puts state in IDLE and clears starve_cnt to 0.
- Outputs after reset: i_rvalid = 0, d_rvalid = 0. m_valid, i_ready and d_ready follow the IDLE combinational rules below.

FSM states: IDLE, WAIT_I, WAIT_D.

IDLE:
- Grant selection (combinational):
  - Fetch wins if i_valid && !d_valid.
  - Fetch also wins if i_valid && d_valid && starve_cnt == STARVE_LIMIT.
  - Otherwise data wins if d_valid.
- m_valid = i_valid || d_valid. m_* fields are muxed from the winner.
- When fetch wins: m_wen = 0, m_wdata = 0, m_wmask = 0.
- Winner's ready = m_ready; loser's ready = 0. There is no combinational path from m_ready to m_valid.
- Handshake (m_valid && m_ready): move to WAIT_I or WAIT_D for the winner.
- starve_cnt update, only on a handshake:
  - Data wins while i_valid is high: starve_cnt increments, saturating at STARVE_LIMIT.
  - Fetch wins: starve_cnt goes to 0.
  - Data wins with i_valid low: starve_cnt goes to 0.
- m_rvalid in IDLE is spurious: ignored, neither rvalid is asserted.

WAIT_I / WAIT_D:
- m_valid = 0, i_ready = 0, d_ready = 0.
- On m_rvalid: owner's rvalid = 1 combinationally, owner's rdata = m_rdata, state returns to IDLE.
- Non-owner rvalid is always 0. Non-owner rdata is don't-care; it is driven 0.
- A new request cannot be accepted in the same cycle as m_rvalid. The earliest next m_valid is one cycle after the response.
- Same-cycle m_rvalid, i_valid and d_valid are legal; the requests are arbitrated in the following IDLE cycle.

Requester rules:
- A requester holds valid and its fields stable until ready.
- A d_valid that arrives while a fetch is outstanding waits; it is not dropped.

Reset mid-transaction:
- State goes to IDLE; the pending response is discarded.
- The downstream must be reset by the same rst. A late m_rvalid after reset is treated as spurious and ignored.

Latency:
- Request path is combinational (0 cycles).
- Response path is combinational from m_rvalid.
- Back-to-back throughput is one transaction per (downstream latency + 1) cycles.

Test Plan:
- Fetch-only: i_valid = 1, i_addr = 0x1000, m_ready = 1 -> m_valid = 1, m_addr = 0x1000, m_wen = 0, i_ready = 1; state WAIT_I. m_rvalid = 1 with m_rdata = 0x00000013 two cycles later -> i_rvalid = 1, i_rdata = 0x13, d_rvalid = 0.
- Simultaneous: i_valid = d_valid = 1, d_addr = 0x2000, d_wen = 1, d_wdata = 0xDEADBEEF, d_wmask = 0x0F -> m_addr = 0x2000, m_wen = 1, m_wmask = 0x0F, d_ready = 1, i_ready = 0. Write response -> d_rvalid = 1; next IDLE cycle grants fetch.
- Starvation, STARVE_LIMIT = 4: i_valid held high, d_valid high for 6 requests -> first 4 grants go to data, 5th goes to fetch, 6th goes to data; starve_cnt reads 0 after the fetch grant.
- Backpressure: d_valid = 1, m_ready = 0 for 3 cycles -> m_valid = 1 and d_ready = 0 throughout, m_addr stable, state stays IDLE. m_ready = 1 -> handshake, state WAIT_D.
- Blocking: fetch outstanding (WAIT_I), d_valid asserted -> m_valid = 0, d_ready = 0 until m_rvalid. The cycle after the response, m_valid = 1 carrying d_addr.
- Reset and spurious response: rst = 1 during WAIT_D -> state IDLE, d_rvalid = 0. m_rvalid pulse after reset -> i_rvalid = d_rvalid = 0. Spurious m_rvalid in IDLE -> no rvalid asserted.
